// File: rtl/mul_pkg.sv
// Shared types and widths for the shift-add 8x8 multiplier.
package mul_pkg;
    localparam int OPW = 8;
    localparam int PRW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul_8x8_ctrl_row.sv
// 8x1 AND row: one partial-product row of the multiplier, gated as a whole.
module Mul_8x1
    import mul_pkg::*;
(
    input  logic           i_gate,
    input  logic [OPW-1:0] i_a,
    input  logic           i_b,
    output logic [OPW-1:0] o_pp
);
    assign o_pp = i_a & {OPW{i_gate & i_b}};
endmodule

// File: rtl/mul_8x8_ctrl.sv
// Sequential shift-add 8x8 unsigned multiplier, one partial-product row per RUN cycle.
module mul_8x8_ctrl
    import mul_pkg::*;
#(
    parameter int EARLY_TERM = 1
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           start,
    input  logic           clear,
    input  logic [OPW-1:0] A,
    input  logic [OPW-1:0] B,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [PRW-1:0] prdct
);
    state_t         r_state;
    state_t         w_state_nxt;
    logic [PRW-1:0] r_a_sh;
    logic [OPW-1:0] r_b_sh;
    logic [PRW-1:0] r_acc;
    logic [2:0]     r_cnt;
    logic [PRW-1:0] r_prdct;

    logic [OPW-1:0] w_a_row;
    logic [OPW-1:0] w_pp;
    logic [PRW-1:0] w_add;
    logic [PRW-1:0] w_acc_nxt;
    logic [OPW-1:0] w_b_nxt;
    logic           w_last;
    logic           w_accept;

    // a_sh is already shifted by cnt; undo it so the row block sees the
    // byte-aligned multiplicand, then re-shift the row into place.
    assign w_a_row   = OPW'(r_a_sh >> r_cnt);
    assign w_add     = {{(PRW-OPW){1'b0}}, w_pp} << r_cnt;
    assign w_acc_nxt = r_acc + w_add;
    assign w_b_nxt   = r_b_sh >> 1;
    assign w_last    = (r_cnt == 3'd7) || ((EARLY_TERM != 0) && (w_b_nxt == '0));
    assign w_accept  = (r_state == IDLE) && start && !clear;

    Mul_8x1 u_row (
        .i_gate (1'b1),
        .i_a    (w_a_row),
        .i_b    (r_b_sh[0]),
        .o_pp   (w_pp)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = RUN;
                RUN:     if (w_last) w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_prdct <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_a_sh  <= '0;
                r_b_sh  <= '0;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_prdct <= '0;
            end else if (w_accept) begin
                r_a_sh  <= {{(PRW-OPW){1'b0}}, A};
                r_b_sh  <= B;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_prdct <= '0;
            end else if (r_state == RUN) begin
                r_acc  <= w_acc_nxt;
                r_a_sh <= r_a_sh << 1;
                r_b_sh <= w_b_nxt;
                r_cnt  <= r_cnt + 3'd1;
                if (w_last) r_prdct <= w_acc_nxt;
            end
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign prdct = r_prdct;
endmodule

// File: tb/tb_mul_8x8_ctrl.sv
// Bench: both EARLY_TERM variants driven in lockstep, checked against a latency/product model.
module tb_mul_8x8_ctrl;
    logic        Clk = 1'b0;
    logic        Rst, start, clear;
    logic [7:0]  A, B;
    logic        ready0, busy0, done0, ready1, busy1, done1;
    logic [15:0] prdct0, prdct1;
    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mul_8x8_ctrl #(.EARLY_TERM(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .start(start), .clear(clear), .A(A), .B(B),
        .ready(ready0), .busy(busy0), .done(done0), .prdct(prdct0));
    mul_8x8_ctrl #(.EARLY_TERM(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .start(start), .clear(clear), .A(A), .B(B),
        .ready(ready1), .busy(busy1), .done(done1), .prdct(prdct1));

    // Iteration count from the arithmetic rule: 8, or highest set bit + 1 (min 1).
    function automatic int iters(input int et, input logic [7:0] b);
        int n;
        if (et == 0) return 8;
        n = 1;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(ready0 && ready1) && k < 20) begin
            tick();
            k++;
        end
        total++;
        if (!(ready0 && ready1)) begin
            bad++;
            $display("FAIL wait_idle: ready0=%0b ready1=%0b required 1/1", ready0, ready1);
        end
    endtask

    // One operation; done counted in edges with the accept edge as 1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit chk_lat);
        int lat0, lat1, bz0, bz1, nd0, nd1, n0, n1;
        logic [15:0] p0, p1, exp;
        wait_idle();
        lat0 = 0; lat1 = 0; bz0 = 0; bz1 = 0; nd0 = 0; nd1 = 0; p0 = 'x; p1 = 'x;
        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (busy0) bz0++;
            if (busy1) bz1++;
            if (done0) begin nd0++; if (lat0 == 0) begin lat0 = cyc; p0 = prdct0; end end
            if (done1) begin nd1++; if (lat1 == 0) begin lat1 = cyc; p1 = prdct1; end end
            tick();
        end
        n0 = iters(0, b); n1 = iters(1, b);
        exp = 16'(a) * 16'(b);
        total += 2;
        if (p0 !== exp) begin bad++; $display("FAIL prod_et0 %0d*%0d: got %0d want %0d", a, b, p0, exp); end
        if (p1 !== exp) begin bad++; $display("FAIL prod_et1 %0d*%0d: got %0d want %0d", a, b, p1, exp); end
        if (chk_lat) begin
            total += 6;
            if (lat0 != n0 + 1) begin bad++; $display("FAIL lat_et0 B=%0d: got %0d want %0d", b, lat0, n0 + 1); end
            if (lat1 != n1 + 1) begin bad++; $display("FAIL lat_et1 B=%0d: got %0d want %0d", b, lat1, n1 + 1); end
            if (bz0 != n0) begin bad++; $display("FAIL busy_et0 B=%0d: got %0d want %0d", b, bz0, n0); end
            if (bz1 != n1) begin bad++; $display("FAIL busy_et1 B=%0d: got %0d want %0d", b, bz1, n1); end
            if (nd0 != 1) begin bad++; $display("FAIL pulses_et0: got %0d want 1", nd0); end
            if (nd1 != 1) begin bad++; $display("FAIL pulses_et1: got %0d want 1", nd1); end
        end
    endtask

    task automatic check_rst_state(input string tag);
        total += 4;
        if ({ready0, ready1} !== 2'b11) begin bad++; $display("FAIL %s ready: got %b want 11", tag, {ready0, ready1}); end
        if ({busy0, busy1} !== 2'b00) begin bad++; $display("FAIL %s busy: got %b want 00", tag, {busy0, busy1}); end
        if ({done0, done1} !== 2'b00) begin bad++; $display("FAIL %s done: got %b want 00", tag, {done0, done1}); end
        if ({prdct0, prdct1} !== 32'h0) begin bad++; $display("FAIL %s prdct: got %h/%h want 0", tag, prdct0, prdct1); end
    endtask

    task automatic test_reset();
        Rst = 1'b1; start = 1'b0; clear = 1'b0; A = '0; B = '0;
        tick(); tick();
        Rst = 1'b0;
        check_rst_state("reset");
    endtask

    task automatic test_vectors();
        run_op(8'd255, 8'd255, 1'b1);
        total++;
        if (prdct0 !== 16'hFE01) begin bad++; $display("FAIL hold_fe01: got %h want fe01", prdct0); end
        run_op(8'd13, 8'd2, 1'b1);
        run_op(8'd13, 8'd0, 1'b1);
        run_op(8'd0, 8'd255, 1'b1);
        run_op(8'd1, 8'd128, 1'b1);
        run_op(8'd200, 8'd1, 1'b1);
    endtask

    task automatic test_same_cycle();
        wait_idle();
        A = 8'd7; B = 8'd9; start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        total++;
        if ({ready0, ready1, busy0, busy1} !== 4'b1100) begin
            bad++; $display("FAIL start_clear: got rdy/busy %b want 1100", {ready0, ready1, busy0, busy1});
        end
    endtask

    task automatic test_clear();
        int nd;
        wait_idle();
        A = 8'd100; B = 8'd200; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total += 2;
        if ({ready0, ready1} !== 2'b11) begin bad++; $display("FAIL clear_ready: got %b want 11", {ready0, ready1}); end
        if ({prdct0, prdct1} !== 32'h0) begin bad++; $display("FAIL clear_prdct: got %h/%h want 0", prdct0, prdct1); end
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done0 || done1) nd++;
            tick();
        end
        total++;
        if (nd != 0) begin bad++; $display("FAIL clear_nodone: got %0d pulses want 0", nd); end
    endtask

    task automatic test_reset_midrun();
        int nd;
        run_op(8'd3, 8'd5, 1'b0);
        wait_idle();
        A = 8'd255; B = 8'd255; start = 1'b1;
        tick();
        tick(); tick();
        Rst = 1'b1;
        tick();
        check_rst_state("rst_midrun");
        Rst = 1'b0; start = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done0 || done1 || busy0 || busy1) nd++;
            tick();
        end
        total++;
        if (nd != 0) begin bad++; $display("FAIL rst_noaccept: got %0d active cycles want 0", nd); end
    endtask

    // Scheduler model: accept at edge k -> done at k+N, next accept at k+N+2.
    task automatic test_back_to_back();
        int nxt [2];
        int dn  [2];
        logic [15:0] ep [2];
        logic d [2];
        logic [15:0] p [2];
        logic [7:0] ca, cb;
        int naccept;
        wait_idle();
        nxt[0] = 0; nxt[1] = 0; dn[0] = -1; dn[1] = -1; naccept = 0;
        start = 1'b1;
        for (int k = 0; k < 80; k++) begin
            ca = 8'($urandom); cb = 8'($urandom);
            A = ca; B = cb;
            tick();
            d[0] = done0; d[1] = done1; p[0] = prdct0; p[1] = prdct1;
            for (int u = 0; u < 2; u++) begin
                if (k == nxt[u]) begin
                    dn[u]  = k + iters(u, cb);
                    nxt[u] = dn[u] + 2;
                    ep[u]  = 16'(ca) * 16'(cb);
                    naccept++;
                end
                total++;
                if (d[u] !== (k == dn[u])) begin
                    bad++; $display("FAIL b2b_done et%0d edge %0d: got %b want %b", u, k, d[u], k == dn[u]);
                end
                if (k == dn[u]) begin
                    total++;
                    if (p[u] !== ep[u]) begin bad++; $display("FAIL b2b_prod et%0d edge %0d: got %0d want %0d", u, k, p[u], ep[u]); end
                end
            end
        end
        start = 1'b0;
        total++;
        if (naccept < 14) begin bad++; $display("FAIL b2b_accepts: got %0d want >=14", naccept); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) run_op(8'($urandom), 8'($urandom >> (i % 8)), 1'b1);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_same_cycle();
        test_clear();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
